ifetch_bridge: RTL and testbench

IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

---
 rtl/ifetch_bridge.sv | 128 ++++++++++++
 tb/tb_ifetch_bridge.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_bridge.sv
// ifetch_bridge: instruction fetch bridge between the core PC and a simple
// req/gnt + rvalid instruction bus. At most one bus transaction is in flight.
// Optional build macro IFETCH_REUSE_EN: when defined, a fetch of the address
// that is already held in the instruction register issues no bus request.
module ifetch_bridge #(
  parameter logic [29:0] RESET_ADDR = 30'h0,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] i_addr,
  input  logic        i_stall,
  output logic [31:0] o_instr,
  output logic        o_hold,
  output logic        o_bus_req,
  output logic [29:0] o_bus_addr,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_err,
  output logic        o_fetch_err,
  output logic [15:0] o_hold_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_BUF
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [29:0] pend_addr;
  logic [29:0] pend_addr_nxt;
  logic [31:0] instr_reg;
  logic [31:0] instr_reg_nxt;
  logic [15:0] hold_cnt;

  logic [31:0] fetched;
  logic        deliver;
  logic        core_free;
  logic        reuse;
  logic        issue;

  // A bus error hands the core a harmless NOP instead of the garbage data.
  assign fetched   = i_bus_err ? NOP_INSTR : i_bus_rdata;
  assign deliver   = (state == S_WAIT) && i_bus_rvalid;
  // The core runs whenever it has an instruction this cycle: a fresh
  // response or the buffered one.
  assign core_free = deliver || (state == S_BUF);

`ifdef IFETCH_REUSE_EN
  assign reuse = (i_addr == pend_addr);
`else
  assign reuse = 1'b0;
`endif

  // Any running cycle without a stall starts the next fetch right away so a
  // zero-wait bus keeps up with one instruction per cycle.
  assign issue = core_free && !i_stall && !reuse;

  assign o_hold_cnt = hold_cnt;

  // Next-state and output decode; the next-fetch issue overrides the per-state defaults.
  always_comb begin
    state_nxt     = state;
    pend_addr_nxt = pend_addr;
    instr_reg_nxt = instr_reg;
    o_bus_req     = 1'b0;
    o_bus_addr    = pend_addr;
    o_hold        = 1'b1;
    o_instr       = instr_reg;
    o_fetch_err   = 1'b0;

    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        o_bus_req = 1'b1;
        if (i_bus_gnt) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_bus_rvalid) begin
          o_hold        = 1'b0;
          o_instr       = fetched;
          instr_reg_nxt = fetched;
          o_fetch_err   = i_bus_err;
          state_nxt     = S_BUF;
        end
      end
      S_BUF: begin
        o_hold = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (issue) begin
      o_bus_req     = 1'b1;
      o_bus_addr    = i_addr;
      pend_addr_nxt = i_addr;
      state_nxt     = i_bus_gnt ? S_WAIT : S_REQ;
    end
  end

  // State, pending address, instruction buffer and saturating hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pend_addr <= RESET_ADDR;
      instr_reg <= NOP_INSTR;
      hold_cnt  <= 16'h0000;
    end else begin
      state     <= state_nxt;
      pend_addr <= pend_addr_nxt;
      instr_reg <= instr_reg_nxt;
      if (o_hold && (hold_cnt != 16'hFFFF)) begin
        hold_cnt <= hold_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_bridge.sv
// tb_ifetch_bridge: directed bring-up sequence followed by randomized core
// and bus traffic, checked every cycle against a transaction-level model.
// Compile with +define+IFETCH_REUSE_EN to exercise the reuse build.
module tb_ifetch_bridge;

  localparam logic [29:0] RESET_ADDR = 30'h0;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] i_addr = '0;
  logic        i_stall = 1'b0;
  logic [31:0] o_instr;
  logic        o_hold;
  logic        o_bus_req;
  logic [29:0] o_bus_addr;
  logic        i_bus_gnt = 1'b0;
  logic        i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        i_bus_err = 1'b0;
  logic        o_fetch_err;
  logic [15:0] o_hold_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifetch_bridge #(
    .RESET_ADDR(RESET_ADDR),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_addr      (i_addr),
    .i_stall     (i_stall),
    .o_instr     (o_instr),
    .o_hold      (o_hold),
    .o_bus_req   (o_bus_req),
    .o_bus_addr  (o_bus_addr),
    .i_bus_gnt   (i_bus_gnt),
    .i_bus_rvalid(i_bus_rvalid),
    .i_bus_rdata (i_bus_rdata),
    .i_bus_err   (i_bus_err),
    .o_fetch_err (o_fetch_err),
    .o_hold_cnt  (o_hold_cnt)
  );

  // Shared comparison helper for literal and model checks.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives the core side for one cycle, just after the rising edge.
  task automatic applyStimulus(input logic stall, input logic [29:0] addr);
    @(posedge clk);
    #1;
    i_stall = stall;
    i_addr  = addr;
  endtask

  // Instruction memory contents seen by the bus agent.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (a == 30'd0) return 32'h0000_0093;
    return {a, 2'b11} ^ 32'hC3A5_0000;
  endfunction

  // Bus agent: grant latency and response latency, negative means random.
  int          gnt_cfg   = 0;
  int          rsp_cfg   = 0;
  int          err_pct   = 0;
  bit          err_force = 1'b0;
  bit          out_valid = 1'b0;
  logic [29:0] out_addr  = '0;
  int          rsp_wait  = 0;
  int          gnt_wait  = 0;

  function automatic int pick_gnt();
    return (gnt_cfg >= 0) ? gnt_cfg : int'($urandom_range(0, 3));
  endfunction

  // Agent drive: grant once the latency has run out, answer the outstanding fetch.
  always @(posedge clk) begin
    #1;
    i_bus_gnt = (gnt_wait == 0);
    if (out_valid && rsp_wait == 0) begin
      i_bus_rvalid = 1'b1;
      i_bus_rdata  = mem_word(out_addr);
      i_bus_err    = err_force || (int'($urandom_range(0, 99)) < err_pct);
    end else begin
      i_bus_rvalid = 1'b0;
      i_bus_rdata  = $urandom;
      i_bus_err    = ($urandom_range(0, 3) == 0);
    end
  end

  // Agent bookkeeping: retire responses, record grants, count down latencies.
  always @(negedge clk) begin
    if (!rst_n) begin
      out_valid = 1'b0;
      rsp_wait  = 0;
      gnt_wait  = pick_gnt();
    end else begin
      if (i_bus_rvalid) begin
        out_valid = 1'b0;
      end else if (out_valid && rsp_wait > 0) begin
        rsp_wait--;
      end
      if (o_bus_req && i_bus_gnt) begin
        out_valid = 1'b1;
        out_addr  = o_bus_addr;
        rsp_wait  = (rsp_cfg >= 0) ? rsp_cfg : int'($urandom_range(0, 2));
        gnt_wait  = pick_gnt();
      end else if (o_bus_req && gnt_wait > 0) begin
        gnt_wait--;
      end
    end
  end

  // Transaction-level model of what the core and bus must see.
  bit          m_start;
  bit          m_await;
  bit          m_reqp;
  bit          m_have;
  logic [29:0] m_req_addr;
  logic [29:0] m_last = RESET_ADDR;
  logic [31:0] m_instr;
  int          m_hold;
  bit          e_deliver, e_free, e_issue, e_reuse, e_req, e_hold;
  logic [29:0] e_addr;
  logic [31:0] e_instr;

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_start    = 1'b1;
      m_await    = 1'b0;
      m_reqp     = 1'b0;
      m_have     = 1'b0;
      m_last     = RESET_ADDR;
      m_req_addr = RESET_ADDR;
      m_instr    = NOP;
      m_hold     = 0;
    end else begin
      e_deliver = m_await && i_bus_rvalid;
      e_free    = e_deliver || m_have;
`ifdef IFETCH_REUSE_EN
      e_reuse   = (i_addr == m_last);
`else
      e_reuse   = 1'b0;
`endif
      e_issue   = e_free && !i_stall && !e_reuse && !m_start;
      e_req     = e_issue || m_reqp;
      e_addr    = e_issue ? i_addr : m_req_addr;
      e_hold    = !e_free;
      e_instr   = e_deliver ? (i_bus_err ? NOP : i_bus_rdata) : m_instr;

      checkOutput("m_hold", 32'(o_hold), 32'(e_hold));
      checkOutput("m_req", 32'(o_bus_req), 32'(e_req));
      checkOutput("m_ferr", 32'(o_fetch_err), 32'(e_deliver && i_bus_err));
      checkOutput("m_hcnt", 32'(o_hold_cnt), 32'(m_hold));
      if (e_req) checkOutput("m_addr", 32'(o_bus_addr), 32'(e_addr));
      if (!e_hold || m_await) checkOutput("m_instr", o_instr, e_instr);

      if (e_deliver) begin
        m_instr = e_instr;
        m_await = 1'b0;
      end
      if (m_start) begin
        m_start    = 1'b0;
        m_reqp     = 1'b1;
        m_req_addr = m_last;
      end else begin
        if (e_issue) m_last = i_addr;
        if (e_req && i_bus_gnt) begin
          m_await = 1'b1;
          m_reqp  = 1'b0;
        end else if (e_issue) begin
          m_reqp     = 1'b1;
          m_req_addr = i_addr;
        end
        m_have = e_free && !e_issue;
      end
      if (e_hold && m_hold < 65535) m_hold++;
    end
  end

  // Directed bring-up with literal expectations, then randomized traffic.
  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hold", 32'(o_hold), 32'd1);
    checkOutput("rst_req", 32'(o_bus_req), 32'd0);
    checkOutput("rst_ferr", 32'(o_fetch_err), 32'd0);
    checkOutput("rst_hcnt", 32'(o_hold_cnt), 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_stall = 1'b0;
    i_addr = 30'd1;
    @(negedge clk);
    checkOutput("c1_req", 32'(o_bus_req), 32'd0);
    checkOutput("c1_hold", 32'(o_hold), 32'd1);

    applyStimulus(1'b0, 30'd1);
    @(negedge clk);
    checkOutput("c2_req", 32'(o_bus_req), 32'd1);
    checkOutput("c2_addr", 32'(o_bus_addr), 32'd0);

    applyStimulus(1'b0, 30'd1);
    @(negedge clk);
    checkOutput("c3_hold", 32'(o_hold), 32'd0);
    checkOutput("c3_instr", o_instr, 32'h0000_0093);
    checkOutput("c3_hcnt", 32'(o_hold_cnt), 32'd2);
    checkOutput("zw_addr1", 32'(o_bus_addr), 32'd1);

    for (int k = 2; k <= 4; k++) begin
      applyStimulus(1'b0, 30'(k));
      if (k == 4) gnt_cfg = 4;
      @(negedge clk);
      checkOutput("zw_hold", 32'(o_hold), 32'd0);
      checkOutput("zw_req", 32'(o_bus_req), 32'd1);
      checkOutput("zw_addr", 32'(o_bus_addr), 32'(k));
    end

    // Grant withheld for the issuing cycle plus three REQ cycles, response one WAIT later.
    applyStimulus(1'b0, 30'd5);
    rsp_cfg = 1;
    @(negedge clk);
    checkOutput("c7_hold", 32'(o_hold), 32'd0);
    checkOutput("c7_addr", 32'(o_bus_addr), 32'd5);
    for (int k = 8; k <= 11; k++) begin
      applyStimulus(1'(k % 2), 30'd9);
      if (k == 11) gnt_cfg = 0;
      @(negedge clk);
      checkOutput("dly_req", 32'(o_bus_req), 32'd1);
      checkOutput("dly_addr", 32'(o_bus_addr), 32'd5);
      checkOutput("dly_hold", 32'(o_hold), 32'd1);
    end
    applyStimulus(1'b0, 30'd9);
    rsp_cfg = 0;
    @(negedge clk);
    checkOutput("c12_hold", 32'(o_hold), 32'd1);
    checkOutput("c12_req", 32'(o_bus_req), 32'd0);
    err_force = 1'b1;

    applyStimulus(1'b1, 30'd5);
    @(negedge clk);
    checkOutput("err_instr", o_instr, NOP);
    checkOutput("err_pulse", 32'(o_fetch_err), 32'd1);
    checkOutput("dly_hcnt", 32'(o_hold_cnt), 32'd7);
    err_force = 1'b0;

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 30'd6);
      @(negedge clk);
      checkOutput("stl_req", 32'(o_bus_req), 32'd0);
      checkOutput("stl_hold", 32'(o_hold), 32'd0);
      checkOutput("stl_instr", o_instr, NOP);
      checkOutput("stl_ferr", 32'(o_fetch_err), 32'd0);
    end

    applyStimulus(1'b0, 30'd5);
    @(negedge clk);
`ifdef IFETCH_REUSE_EN
    checkOutput("reuse_req", 32'(o_bus_req), 32'd0);
    checkOutput("reuse_instr", o_instr, NOP);
`else
    checkOutput("same_req", 32'(o_bus_req), 32'd1);
    checkOutput("same_addr", 32'(o_bus_addr), 32'd5);
`endif
    applyStimulus(1'b0, 30'd6);
    @(negedge clk);
    checkOutput("next_req", 32'(o_bus_req), 32'd1);
    checkOutput("next_addr", 32'(o_bus_addr), 32'd6);

    gnt_cfg = -1;
    rsp_cfg = -1;
    err_pct = 15;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 30),
                    ($urandom_range(0, 3) == 0) ? m_last : 30'($urandom_range(0, 15)));
      @(negedge clk);
      if (i == 700) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_hold", 32'(o_hold), 32'd1);
        checkOutput("arst_req", 32'(o_bus_req), 32'd0);
        checkOutput("arst_ferr", 32'(o_fetch_err), 32'd0);
        checkOutput("arst_hcnt", 32'(o_hold_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 30'd3);
        @(negedge clk);
        checkOutput("arst_first", 32'(o_bus_addr), 32'(RESET_ADDR));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
